// File: rtl/uart_rx_sched.sv
// Round-robin scheduler sharing one UART receiver between two byte clients.
// Handles the receiver go/dr handshake, request timeouts and the post-abort guard window.
module uart_rx_sched #(
    parameter int unsigned CLK_FREQ       = 66_000_000,
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       rx_go,
    input  logic       rx_dr,
    input  logic [7:0] rx_data,
    output logic       busy
);

    localparam int unsigned BIT_TIME  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned GUARD_MAX = (BIT_TIME > 0) ? 10 * BIT_TIME - 1 : 0;
    localparam int unsigned TO_MAX    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned TO_W      = (TO_MAX > 1) ? $clog2(TO_MAX + 1) : 1;
    localparam int unsigned GUARD_W   = (GUARD_MAX > 1) ? $clog2(GUARD_MAX + 1) : 1;

    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_MAX);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_MAX);

    typedef enum logic [1:0] {StIdle, StArm, StAck, StGuard} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               rx_go_q, rx_go_d;
    logic               busy_q, busy_d;
    logic               pick;
    logic [1:0]         grant_onehot;

    assign grant_onehot = grant_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        to_cnt_d      = to_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        rsp_valid_d   = 2'b00;
        rsp_data_d    = 8'h00;
        rsp_timeout_d = 1'b0;
        rx_go_d       = 1'b0;
        // Contention goes to the client that was not served last.
        pick          = (req == 2'b11) ? ~last_grant_q : req[1];

        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    to_cnt_d     = '0;
                    rx_go_d      = 1'b1;
                    state_d      = StArm;
                end
            end
            StArm: begin
                rx_go_d = 1'b1;
                if (rx_dr) begin
                    rsp_valid_d = grant_onehot;
                    rsp_data_d  = rx_data;
                    rx_go_d     = 1'b0;
                    state_d     = StAck;
                end else if (TIMEOUT_CYCLES != 0 && to_cnt_q == TO_LAST) begin
                    rsp_valid_d   = grant_onehot;
                    rsp_timeout_d = 1'b1;
                    rx_go_d       = 1'b0;
                    guard_cnt_d   = GUARD_LOAD;
                    state_d       = StGuard;
                end else if (TIMEOUT_CYCLES != 0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StAck: begin
                if (!rx_dr) begin
                    state_d = StIdle;
                end
            end
            StGuard: begin
                // Any frame landing here is drained and dropped.
                if (guard_cnt_q != '0) begin
                    guard_cnt_d = guard_cnt_q - GUARD_W'(1);
                end else if (!rx_dr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            to_cnt_q      <= '0;
            guard_cnt_q   <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            rx_go_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            to_cnt_q      <= to_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rx_go_q       <= rx_go_d;
            busy_q        <= busy_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rx_go       = rx_go_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_sched.sv
// Scoreboard bench for uart_rx_sched: the bench plays the receiver and queues expected responses.
// Every tick samples outputs 1 time unit after the rising edge and retires responses in order.
module tb_uart_rx_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       rx_go;
    logic       rx_dr;
    logic [7:0] rx_data;
    logic       busy;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] d;
        logic       t;
    } exp_t;

    exp_t sb[$];
    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   go_cyc    = 0;
    int   pulse_cyc = 0;
    int   inv_err   = 0;
    logic prev_go   = 1'b0;

    uart_rx_sched #(
        .CLK_FREQ      (10),
        .BAUD_RATE     (1),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .rx_go      (rx_go),
        .rx_dr      (rx_dr),
        .rx_data    (rx_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rx_go === 1'b1 && prev_go !== 1'b1) go_cyc = cyc;
        prev_go = rx_go;
        if (rsp_valid === 2'b11 || (rsp_valid === 2'b00 && (rsp_data !== 8'h00 ||
            rsp_timeout !== 1'b0)) || (rx_go === 1'b1 && busy !== 1'b1)) inv_err++;
        if (rsp_valid !== 2'b00) begin
            pulse_cyc = cyc;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: valid=%b data=%h timeout=%b, required none",
                         rsp_valid, rsp_data, rsp_timeout);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.v || rsp_data !== e.d || rsp_timeout !== e.t) begin
                    fails++;
                    $display("FAIL rsp: valid=%b data=%h timeout=%b, required %b %h %b",
                             rsp_valid, rsp_data, rsp_timeout, e.v, e.d, e.t);
                end
            end
        end
    endtask

    task automatic wait_go(input int limit);
        int n = 0;
        while (rx_go !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        tests++;
        if (rx_go !== 1'b1) begin
            fails++;
            $display("FAIL grant_wait: rx_go=%b after %0d cycles, required 1", rx_go, limit);
        end
    endtask

    // Receiver model: byte ready after delay cycles, dr cleared one cycle after go falls.
    task automatic serve(input logic c, input logic [7:0] d, input int delay, input logic drop);
        int n = 0;
        wait_go(200);
        if (drop) req = 2'b00;
        repeat (delay) tick();
        sb.push_back(exp_t'{v: (c ? 2'b10 : 2'b01), d: d, t: 1'b0});
        rx_dr   = 1'b1;
        rx_data = d;
        while (rx_go === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        tick();
        rx_dr   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_timeout_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 700) begin
            tick();
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout_rsp: none after %0d cycles, required one", n);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        rx_dr = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        tests++;
        if ({rx_go, rsp_valid, rsp_data, rsp_timeout, busy} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: go=%b valid=%b data=%h to=%b busy=%b, required all 0",
                     rx_go, rsp_valid, rsp_data, rsp_timeout, busy);
        end
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if (busy !== 1'b0 || rx_go !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: busy=%b go=%b, required 0 0", busy, rx_go);
        end
    endtask

    task automatic test_single();
        req = 2'b01;
        serve(1'b0, 8'h5A, 40, 1'b1);
        tests++;
        if (pulse_cyc - go_cyc !== 41) begin
            fails++;
            $display("FAIL single_latency: %0d cycles, required 41", pulse_cyc - go_cyc);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || rx_go !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: busy=%b go=%b, required 0 0", busy, rx_go);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        serve(1'b0, 8'h11, 3, 1'b0);
        serve(1'b1, 8'h22, 7, 1'b0);
        serve(1'b0, 8'h33, 1, 1'b0);
        serve(1'b1, 8'h44, 12, 1'b0);
        req = 2'b00;
        repeat (4) tick();
        tests++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL contention_done: pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int start;
        req = 2'b10;
        wait_go(20);
        req = 2'b01;
        sb.push_back(exp_t'{v: 2'b10, d: 8'h00, t: 1'b1});
        wait_timeout_rsp();
        tests++;
        if (pulse_cyc - go_cyc !== 500 || rx_go !== 1'b0) begin
            fails++;
            $display("FAIL timeout_timing: %0d cycles go=%b, required 500 0",
                     pulse_cyc - go_cyc, rx_go);
        end
        start = pulse_cyc;
        wait_go(300);
        tests++;
        if (go_cyc - start !== 101) begin
            fails++;
            $display("FAIL guard_gap: %0d cycles, required 101", go_cyc - start);
        end
        serve(1'b0, 8'h01, 5, 1'b1);
    endtask

    task automatic test_late_frame();
        int start;
        req = 2'b10;
        wait_go(20);
        req = 2'b01;
        sb.push_back(exp_t'{v: 2'b10, d: 8'h00, t: 1'b1});
        wait_timeout_rsp();
        start = pulse_cyc;
        // Stray frame arrives mid-guard and outlives the guard counter.
        for (int j = 1; j <= 120; j++) begin
            tick();
            if (j == 30) begin
                rx_dr   = 1'b1;
                rx_data = 8'hEE;
            end
            if (j == 120) begin
                rx_dr   = 1'b0;
                rx_data = 8'h00;
            end
        end
        wait_go(50);
        tests++;
        if (go_cyc - start !== 122) begin
            fails++;
            $display("FAIL late_frame_gap: %0d cycles, required 122", go_cyc - start);
        end
        serve(1'b0, 8'h02, 2, 1'b1);
    endtask

    task automatic test_tie();
        req = 2'b10;
        serve(1'b1, 8'h77, 499, 1'b1);
        tests++;
        if (pulse_cyc - go_cyc !== 500) begin
            fails++;
            $display("FAIL tie_latency: %0d cycles, required 500", pulse_cyc - go_cyc);
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL tie_ack: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_arm();
        req = 2'b11;
        wait_go(20);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        tests++;
        if (rx_go !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: go=%b valid=%b busy=%b, required 0 00 0",
                     rx_go, rsp_valid, busy);
        end
        tick();
        rst = 1'b0;
        serve(1'b0, 8'h3C, 3, 1'b1);
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_late_frame();
        test_tie();
        test_reset_mid_arm();
        tests++;
        if (inv_err !== 0) begin
            fails++;
            $display("FAIL invariants: %0d violating cycles, required 0", inv_err);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d responses never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
